// File: rtl/rsa_pkg.sv
// Shared RSA package: FSM state encoding and latency constants.
// Used by the encrypt engine, the keygen/decrypt core and the harness.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQR,
        MUL,
        SEL,
        DONE
    } rsa_state_e;

    function automatic int MULT_LAT(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int ENC_LAT(input int w);
        return 4 * w * (2 * w + 1) + 2;
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Fixed-latency interleaved shift-add modular multiplier, one bit per cycle.
// done marks the cycle whose edge commits the last step; r is final after it.
module mod_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   r,
    output logic                 done
);

    localparam int W2 = 2 * WIDTH;
    localparam int KW = $clog2(W2);

    logic [W2-1:0] a_q;
    logic [W2-1:0] b_q;
    logic [W2-1:0] n_q;
    logic [W2-1:0] r_q;
    logic [KW-1:0] i_q;
    logic          run_q;

    logic [W2:0]   n_ext;
    logic [W2:0]   dbl;
    logic [W2:0]   dbl_red;
    logic [W2:0]   sum;
    logic [W2:0]   sum_red;
    logic [W2-1:0] r_nxt;
    logic          unused_msb;

    // Both reductions stay below n, so the extra bit only guards the compare.
    always_comb begin
        n_ext   = {1'b0, n_q};
        dbl     = {r_q, 1'b0};
        dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum     = dbl_red + {1'b0, a_q};
        sum_red = (sum >= n_ext) ? sum - n_ext : sum;
        r_nxt   = b_q[i_q] ? sum_red[W2-1:0] : dbl_red[W2-1:0];
    end

    assign unused_msb = ^{dbl_red[W2], sum_red[W2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            r_q   <= '0;
            i_q   <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            r_q   <= '0;
            i_q   <= KW'(W2 - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            r_q <= r_nxt;
            i_q <= i_q - 1'b1;
            if (i_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

    assign r    = r_q;
    assign done = run_q && (i_q == '0);

endmodule

// File: rtl/rsa_encrypt_ct.sv
// Constant-time RSA encryption: c = m^e mod n, square-and-always-multiply
// over a full 2*WIDTH-bit exponent scan.
module rsa_encrypt_ct #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   m,
    input  logic [2*WIDTH-1:0]   e,
    input  logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy,
    output logic                 finish,
    output logic                 err
);

    import rsa_pkg::*;

    localparam int            W2    = 2 * WIDTH;
    localparam int            KW    = $clog2(W2);
    localparam logic [W2-1:0] ONE   = W2'(1);
    localparam logic [W2-1:0] TWO   = W2'(2);
    localparam logic [KW-1:0] K_TOP = KW'(W2 - 1);

    rsa_state_e state_q;
    rsa_state_e state_d;

    logic [W2-1:0] base_q;
    logic [W2-1:0] exp_q;
    logic [W2-1:0] mod_q;
    logic [W2-1:0] acc_q;
    logic [W2-1:0] sq_q;
    logic [W2-1:0] c_q;
    logic [KW-1:0] k_q;
    logic          err_q;
    logic          err_out_q;
    logic          finish_q;
    logic          mul_go_q;

    logic          bad;
    logic [W2-1:0] acc_nxt;
    logic          mm_start;
    logic [W2-1:0] mm_a;
    logic [W2-1:0] mm_b;
    logic [W2-1:0] mm_r;
    logic          mm_done;

    assign bad     = (mod_q < TWO) || (base_q >= mod_q);
    // Pure select: both products are always computed.
    assign acc_nxt = exp_q[k_q] ? mm_r : sq_q;

    mod_mult #(
        .WIDTH (WIDTH)
    ) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (mod_q),
        .r     (mm_r),
        .done  (mm_done)
    );

    always_comb begin
        state_d  = state_q;
        mm_start = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                if (bad) begin
                    state_d = DONE;
                end else begin
                    state_d  = SQR;
                    mm_start = 1'b1;
                    mm_a     = ONE;
                    mm_b     = ONE;
                end
            end
            SQR: begin
                if (mm_done) state_d = MUL;
            end
            MUL: begin
                if (mul_go_q) begin
                    mm_start = 1'b1;
                    mm_a     = mm_r;
                    mm_b     = base_q;
                end
                if (mm_done) state_d = SEL;
            end
            SEL: begin
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = SQR;
                    mm_start = 1'b1;
                    mm_a     = acc_nxt;
                    mm_b     = acc_nxt;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            acc_q     <= '0;
            sq_q      <= '0;
            c_q       <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
            finish_q  <= 1'b0;
            mul_go_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= 1'b0;
            mul_go_q <= (state_q == SQR) && mm_done;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q <= m;
                        exp_q  <= e;
                        mod_q  <= n;
                    end
                end
                CHECK: begin
                    err_q <= bad;
                    acc_q <= ONE;
                    k_q   <= K_TOP;
                end
                MUL: begin
                    if (mul_go_q) sq_q <= mm_r;
                end
                SEL: begin
                    acc_q <= acc_nxt;
                    if (k_q != '0) k_q <= k_q - 1'b1;
                end
                DONE: begin
                    finish_q  <= 1'b1;
                    err_out_q <= err_q;
                    c_q       <= err_q ? '0 : acc_q;
                end
                default: ;
            endcase
        end
    end

    assign c      = c_q;
    assign busy   = (state_q != IDLE) || finish_q;
    assign finish = finish_q;
    assign err    = err_out_q;

endmodule

// File: tb/tb_rsa_encrypt_ct.sv
// Bench for rsa_encrypt_ct: directed plan plus random operands
// against a plain modular-exponentiation reference.
module tb_rsa_encrypt_ct;

    localparam int LAT     = 4 * 8 * (2 * 8 + 1) + 2;
    localparam int LAT_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] m_a = '0, e_a = '0, n_a = '0;
    logic [15:0] m_b = '0, e_b = '0, n_b = '0;
    logic [15:0] c_a, c_b;
    logic        busy_a, busy_b, finish_a, finish_b, err_a, err_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rsa_encrypt_ct #(.WIDTH(8)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_a),
        .m      (m_a),
        .e      (e_a),
        .n      (n_a),
        .c      (c_a),
        .busy   (busy_a),
        .finish (finish_a),
        .err    (err_a)
    );

    rsa_encrypt_ct #(.WIDTH(8)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_b),
        .m      (m_b),
        .e      (e_b),
        .n      (n_b),
        .c      (c_b),
        .busy   (busy_b),
        .finish (finish_b),
        .err    (err_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint ref_pow(input longint bm, input longint ex, input longint md);
        longint r = 1;
        longint b = bm % md;
        longint x = ex;
        while (x > 0) begin
            if (x % 2 == 1) r = (r * b) % md;
            b = (b * b) % md;
            x = x / 2;
        end
        return r % md;
    endfunction

    function automatic bit ref_bad(input longint bm, input longint md);
        return (md < 2) || (bm >= md);
    endfunction

    task automatic run_op(input logic [15:0] m, input logic [15:0] e,
                          input logic [15:0] n, input string tag);
        int  lat;
        bit  seen;
        bit  bad;
        longint exp_c;
        @(negedge clk);
        m_a = m;
        e_a = e;
        n_a = n;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check({tag, " busy"}, busy_a, 1);
        m_a = 16'($urandom);
        e_a = 16'($urandom);
        n_a = 16'($urandom);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (finish_a) seen = 1'b1;
        end
        bad = ref_bad(m, n);
        exp_c = bad ? 0 : ref_pow(m, e, n);
        check({tag, " finish"}, seen, 1);
        check({tag, " latency"}, lat, bad ? LAT_ERR : LAT);
        check({tag, " c"}, c_a, exp_c);
        check({tag, " err"}, err_a, bad);
    endtask

    initial begin
        int fa, fb, cnt, first;
        logic [15:0] rm, re, rn;

        repeat (3) @(posedge clk);
        #1;
        check("reset c", c_a, 0);
        check("reset busy", busy_a, 0);
        check("reset finish", finish_a, 0);
        check("reset err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd65, 16'd17, 16'd3233, "textbook");

        // Two instances, same modulus and message, very different exponents.
        @(negedge clk);
        m_a = 16'd65; e_a = 16'hFFFF; n_a = 16'd3233;
        m_b = 16'd65; e_b = 16'h0001; n_b = 16'd3233;
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        fa = -1;
        fb = -1;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (finish_a && fa < 0) fa = i;
            if (finish_b && fb < 0) fb = i;
        end
        check("ct same cycle", fa, fb);
        check("ct latency", fa, LAT);
        check("ct c e=ffff", c_a, ref_pow(65, 16'hFFFF, 3233));
        check("ct c e=1", c_b, 65);

        run_op(16'd0, 16'd17, 16'd3233, "m zero");
        run_op(16'd5, 16'd0, 16'd3233, "e zero");
        run_op(16'd3233, 16'd17, 16'd3233, "m eq n");
        run_op(16'd0, 16'd17, 16'd1, "n one");
        run_op(16'd65, 16'd17, 16'd3233, "after err");

        // Restarts during an operation must be dropped.
        @(negedge clk);
        m_a = 16'd65; e_a = 16'd17; n_a = 16'd3233;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        cnt = 0;
        first = -1;
        for (int i = 1; i <= LAT + 40; i++) begin
            start_a = (i == 10 || i == 300);
            if (start_a) begin
                m_a = 16'd7; e_a = 16'd3; n_a = 16'd100;
            end
            @(posedge clk);
            #1;
            if (finish_a) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        start_a = 1'b0;
        check("repulse count", cnt, 1);
        check("repulse latency", first, LAT);
        check("repulse c", c_a, 2790);

        // Abort with reset mid-run.
        @(negedge clk);
        m_a = 16'd123; e_a = 16'd4567; n_a = 16'd40000;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_a, 0);
        check("abort c", c_a, 0);
        check("abort finish", finish_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (finish_a) cnt++;
        end
        check("abort no finish", cnt, 0);
        run_op(16'd65, 16'd17, 16'd3233, "post reset");

        for (int t = 0; t < 8; t++) begin
            rn = 16'($urandom_range(65535, 2));
            rm = 16'($urandom_range(int'(rn) - 1, 0));
            re = 16'($urandom);
            if (t == 3) rm = rn;
            if (t == 6) rn = 16'($urandom_range(1, 0));
            run_op(rm, re, rn, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
